// File: rtl/pack_val_pkg.sv
// rtl/pack_val_pkg.sv - shared state encoding and flag bit positions for the result packer
package pack_val_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit positions inside out_flags
    localparam int FLAG_SPC = 0;   // special (Inf/NaN) input
    localparam int FLAG_UNF = 1;   // subnormal or zero result
    localparam int FLAG_OVF = 2;   // exponent overflow to Inf

    localparam int BIAS = 127;

endpackage

// File: rtl/pack_val.sv
// rtl/pack_val.sv - normalises sign/exponent/mantissa sum into an IEEE-754 word, one shift per cycle
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid, in_ready    input handshake (ready only in IDLE, low during reset)
//   sign_in, exp_in       result sign, biased exponent (0 treated as 1)
//   man_in                {carry, hidden, fraction}
//   out_valid, out_ready  output handshake, result held until accepted
//   out_word              packed {sign, exponent, fraction}
//   out_flags             {overflow, underflow, special}
module pack_val
    import pack_val_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    sign_in,
    input  logic [EXP_W-1:0]        exp_in,
    input  logic [FRAC_W+1:0]       man_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+FRAC_W:0]   out_word,
    output logic [2:0]              out_flags
);

    localparam int XW = EXP_W + 2;          // internal exponent carries headroom for +1
    localparam int MW = FRAC_W + 2;
    localparam int WW = 1 + EXP_W + FRAC_W;
    localparam logic [XW-1:0]    EXP_TOP = XW'((1 << EXP_W) - 1);
    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    state_t             state, state_nxt;
    logic               sign_r, sign_nxt;
    logic [XW-1:0]      exp_r, exp_nxt, exp_inc;
    logic [MW-1:0]      man_r, man_nxt, man_sh;
    logic [WW-1:0]      word_nxt;
    logic [2:0]         flags_nxt;
    logic               out_load;

    function automatic logic [WW-1:0] pack(input logic s, input logic [EXP_W-1:0] e,
                                           input logic [FRAC_W-1:0] f);
        return {s, e, f};
    endfunction

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Datapath and result registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sign_r    <= 1'b0;
            exp_r     <= '0;
            man_r     <= '0;
            out_word  <= '0;
            out_flags <= '0;
        end else begin
            sign_r <= sign_nxt;
            exp_r  <= exp_nxt;
            man_r  <= man_nxt;
            if (out_load) begin
                out_word  <= word_nxt;
                out_flags <= flags_nxt;
            end
        end
    end

    // Next-state and normalisation step
    always_comb begin
        state_nxt = state;
        sign_nxt  = sign_r;
        exp_nxt   = exp_r;
        man_nxt   = man_r;
        word_nxt  = out_word;
        flags_nxt = out_flags;
        out_load  = 1'b0;
        man_sh    = man_r >> 1;
        exp_inc   = exp_r + XW'(1);
        case (state)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_nxt  = sign_in;
                    exp_nxt   = (exp_in == '0) ? XW'(1) : XW'(exp_in);
                    man_nxt   = man_in;
                    state_nxt = ST_NORM;
                end
            end
            ST_NORM: begin
                if (exp_r == EXP_TOP) begin
                    word_nxt  = pack(sign_r, EXP_ONES, man_r[FRAC_W-1:0]);
                    flags_nxt = 3'b001;
                    out_load  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (man_r == '0) begin
                    word_nxt  = pack(sign_r, '0, '0);
                    flags_nxt = 3'b010;
                    out_load  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (man_r[MW-1]) begin
                    // Carry out: shift right once, the dropped bit is truncated
                    man_nxt = man_sh;
                    exp_nxt = exp_inc;
                    if (exp_inc >= EXP_TOP) begin
                        word_nxt  = pack(sign_r, EXP_ONES, '0);
                        flags_nxt = 3'b100;
                    end else begin
                        word_nxt  = pack(sign_r, exp_inc[EXP_W-1:0], man_sh[FRAC_W-1:0]);
                        flags_nxt = 3'b000;
                    end
                    out_load  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (man_r[MW-2]) begin
                    word_nxt  = pack(sign_r, exp_r[EXP_W-1:0], man_r[FRAC_W-1:0]);
                    flags_nxt = 3'b000;
                    out_load  = 1'b1;
                    state_nxt = ST_DONE;
                end else if (exp_r <= XW'(1)) begin
                    word_nxt  = pack(sign_r, '0, man_r[FRAC_W-1:0]);
                    flags_nxt = 3'b010;
                    out_load  = 1'b1;
                    state_nxt = ST_DONE;
                end else begin
                    man_nxt = man_r << 1;
                    exp_nxt = exp_r - XW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs
    always_comb begin
        in_ready  = (state == ST_IDLE) && rst_n;
        out_valid = (state == ST_DONE);
    end

endmodule

// File: tb/tb_pack_val.sv
// tb/tb_pack_val.sv - directed self-checking bench for pack_val
module tb_pack_val;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        sign_in;
    logic [7:0]  exp_in;
    logic [24:0] man_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_word;
    logic [2:0]  out_flags;

    int total = 0;
    int bad   = 0;
    int lat;

    always #5 clk = ~clk;

    pack_val #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sign_in   (sign_in),
        .exp_in    (exp_in),
        .man_in    (man_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_word  (out_word),
        .out_flags (out_flags)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
        end
    endtask

    // Called at a negedge with in_ready expected high
    task automatic accept(input logic s, input logic [7:0] e, input logic [24:0] m);
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); @(negedge clk); n++;
        end
        check("accept_ready", {31'b0, in_ready}, 32'd1);
        sign_in  = s;
        exp_in   = e;
        man_in   = m;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(posedge clk); @(negedge clk); lat++;
        end
    endtask

    task automatic release_out;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("drop_valid", {31'b0, out_valid}, 32'd0);
        check("back_idle",  {31'b0, in_ready},  32'd1);
    endtask

    task automatic run(input string tag, input logic s, input logic [7:0] e, input logic [24:0] m,
                       input logic [31:0] w, input logic [2:0] f, input int l);
        accept(s, e, m);
        check({tag, "_word"},  out_word,            w);
        check({tag, "_flags"}, {29'b0, out_flags},  {29'b0, f});
        check({tag, "_lat"},   lat,                 l);
        release_out();
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sign_in   = 1'b0;
        exp_in    = 8'h0;
        man_in    = 25'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_word",  out_word,           32'h0);
        check("rst_flags", {29'b0, out_flags}, 32'd0);
        check("rst_ready", {31'b0, in_ready},  32'd0);
        rst_n = 1'b1;
        #1;
        check("rel_ready", {31'b0, in_ready},  32'd1);
        @(negedge clk);

        run("one_plus_one", 1'b0, 8'h7F, 25'h1000000, 32'h40000000, 3'b000, 2);
        run("one_lshift",   1'b0, 8'h80, 25'h0400000, 32'h3F800000, 3'b000, 3);
        run("overflow",     1'b0, 8'hFE, 25'h1000000, 32'h7F800000, 3'b100, 2);
        run("subnormal",    1'b0, 8'h02, 25'h0000001, 32'h00000002, 3'b010, 3);
        run("neg_zero",     1'b1, 8'h80, 25'h0000000, 32'h80000000, 3'b010, 2);
        run("special",      1'b0, 8'hFF, 25'h0000001, 32'h7F800001, 3'b001, 2);
        run("exp0_as_1",    1'b0, 8'h00, 25'h0000001, 32'h00000001, 3'b010, 2);
        run("exp1",         1'b0, 8'h01, 25'h0000001, 32'h00000001, 3'b010, 2);
        run("max_shift",    1'b0, 8'h7F, 25'h0000001, 32'h34000000, 3'b000, 25);
        run("carry_trunc",  1'b0, 8'h7F, 25'h1FFFFFF, 32'h407FFFFF, 3'b000, 2);
        run("neg_normal",   1'b1, 8'h81, 25'h0C00000, 32'hC0C00000, 3'b000, 2);

        // Backpressure: result held, new input ignored
        accept(1'b0, 8'h7F, 25'h1000000);
        check("bp_first", out_word, 32'h40000000);
        sign_in  = 1'b1;
        exp_in   = 8'h10;
        man_in   = 25'h0800000;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_valid", {31'b0, out_valid}, 32'd1);
            check("bp_word",  out_word,           32'h40000000);
            check("bp_flags", {29'b0, out_flags}, 32'd0);
            check("bp_ready", {31'b0, in_ready},  32'd0);
        end
        in_valid = 1'b0;
        release_out();

        // Reset during a long normalisation
        sign_in  = 1'b0;
        exp_in   = 8'h7F;
        man_in   = 25'h0000001;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("mid_busy", {31'b0, in_ready}, 32'd0);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("abort_valid", {31'b0, out_valid}, 32'd0);
        check("abort_ready", {31'b0, in_ready},  32'd0);
        rst_n = 1'b1;
        #1;
        check("abort_idle", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        for (int i = 0; i < 30; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("abort_noout", {31'b0, out_valid}, 32'd0);
        end
        run("after_abort", 1'b0, 8'h80, 25'h0400000, 32'h3F800000, 3'b000, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
